// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with multi-word blocks, LRU replacement, flush and hit/miss counters.
// Latency: a hit returns its word combinationally; a miss hits WORDS+1 cycles after the request with a zero-wait memory.
// Backpressure: iwait stalls the refill word by word; dropping imemREN or raising iflush aborts a refill.
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             iflush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    // Pairwise recency matrix: bit [i*WAYS+j] (i<j) set means way i is newer than way j.
    // All-zero is a consistent order (higher way number newer), so reset needs no seeding.
    localparam int LRU_W  = WAYS * WAYS;

    typedef enum logic {
        ST_CHECK = 1'b0,
        ST_FILL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WAYS-1:0]    r_valid [SETS];
    logic [LRU_W-1:0]   r_lru   [SETS];
    logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
    logic [31:0]        r_data  [SETS][WAYS][WORDS];
    logic [31:0]        r_buf   [WORDS];
    logic [31:0]        r_base;
    logic [WAY_W-1:0]   r_victim;
    logic [OFF_WS-1:0]  r_cnt;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [31:0]        w_waddr;
    logic [OFF_WS-1:0]  w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_fidx;
    logic [TAG_W-1:0]   w_ftag;
    logic               w_hit_any;
    logic [WAY_W-1:0]   w_hit_way;
    logic [31:0]        w_hit_word;
    logic [WAY_W-1:0]   w_lru_way;
    logic [WAY_W-1:0]   w_victim;
    logic               w_lookup;
    logic               w_hit;
    logic               w_miss;
    logic               w_accept;
    logic               w_last;
    logic               w_done;

    // Mark way t as the most recently used one in a set's recency matrix.
    function automatic logic [LRU_W-1:0] f_touch(input logic [LRU_W-1:0] m, input logic [WAY_W-1:0] t);
        logic [LRU_W-1:0] r;
        r = m;
        for (int i = 0; i < WAYS; i++) begin
            for (int j = i + 1; j < WAYS; j++) begin
                if (WAY_W'(i) == t) begin
                    r[i*WAYS+j] = 1'b1;
                end else if (WAY_W'(j) == t) begin
                    r[i*WAYS+j] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // True when way i was used more recently than way j.
    function automatic logic f_newer(input logic [LRU_W-1:0] m, input int i, input int j);
        if (i < j) begin
            return m[i*WAYS+j];
        end
        return !m[j*WAYS+i];
    endfunction

    assign w_waddr = imemaddr >> 2;
    assign w_off   = OFF_WS'(w_waddr & 32'(WORDS - 1));
    assign w_idx   = IDX_W'(w_waddr >> OFF_W);
    assign w_tag   = TAG_W'(w_waddr >> (OFF_W + IDX_W));
    assign w_fidx  = IDX_W'(r_base >> (OFF_W + 2));
    assign w_ftag  = TAG_W'(r_base >> (OFF_W + IDX_W + 2));

    assign w_lookup = (r_state == ST_CHECK) && imemREN && !iflush;
    assign w_hit    = w_lookup && w_hit_any;
    assign w_miss   = w_lookup && !w_hit_any;
    assign w_accept = (r_state == ST_FILL) && imemREN && !iflush && !iwait;
    assign w_last   = (32'(r_cnt) == 32'(WORDS - 1));
    assign w_done   = w_accept && w_last;

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Tag compare across all ways of the addressed set.
    always_comb begin
        w_hit_any  = 1'b0;
        w_hit_way  = '0;
        w_hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit_any  = 1'b1;
                w_hit_way  = WAY_W'(w);
                w_hit_word = r_data[w_idx][w][w_off];
            end
        end
    end

    // Victim choice: lowest invalid way first, otherwise the least recently used way.
    always_comb begin
        logic v_is_lru;
        logic v_inv_found;
        w_lru_way   = '0;
        w_victim    = '0;
        v_is_lru    = 1'b0;
        v_inv_found = 1'b0;
        for (int v = 0; v < WAYS; v++) begin
            v_is_lru = 1'b1;
            for (int j = 0; j < WAYS; j++) begin
                if ((j != v) && !f_newer(r_lru[w_idx], j, v)) begin
                    v_is_lru = 1'b0;
                end
            end
            if (v_is_lru) begin
                w_lru_way = WAY_W'(v);
            end
        end
        w_victim = w_lru_way;
        for (int w = 0; w < WAYS; w++) begin
            if (!v_inv_found && !r_valid[w_idx][w]) begin
                w_victim    = WAY_W'(w);
                v_inv_found = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_CHECK;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and fetch/memory outputs.
    always_comb begin
        w_next   = r_state;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        case (r_state)
            ST_CHECK: begin
                if (w_hit) begin
                    ihit     = 1'b1;
                    imemload = w_hit_word;
                end else if (w_miss) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (iflush || !imemREN) begin
                    w_next = ST_CHECK;
                end else begin
                    iREN  = 1'b1;
                    iaddr = r_base + (32'(r_cnt) << 2);
                    if (!iwait && w_last) begin
                        w_next = ST_CHECK;
                    end
                end
            end
            default: w_next = ST_CHECK;
        endcase
    end

    // Valid/LRU bookkeeping, refill control registers and performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_lru[s]   <= '0;
            end
            r_base     <= '0;
            r_victim   <= '0;
            r_cnt      <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (iflush) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_lru[s]   <= '0;
            end
            r_cnt <= '0;
        end else begin
            if (w_hit) begin
                r_lru[w_idx] <= f_touch(r_lru[w_idx], w_hit_way);
                r_hit_cnt    <= r_hit_cnt + 1'b1;
            end
            if (w_miss) begin
                r_base   <= imemaddr & ~32'(WORDS * 4 - 1);
                r_victim <= w_victim;
                r_cnt    <= '0;
            end
            if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_done) begin
                r_valid[w_fidx][r_victim] <= 1'b1;
                r_lru[w_fidx]             <= f_touch(r_lru[w_fidx], r_victim);
                r_miss_cnt                <= r_miss_cnt + 1'b1;
            end
        end
    end

    // Refill words collect in a side buffer so an aborted fill never disturbs the victim line.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_buf[r_cnt] <= iload;
        end
        if (w_done) begin
            r_tag[w_fidx][r_victim] <= w_ftag;
            for (int k = 0; k < WORDS; k++) begin
                r_data[w_fidx][r_victim][k] <= (OFF_WS'(k) == r_cnt) ? iload : r_buf[k];
            end
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed table, corner sequences and random accesses for icache_assoc (SETS=8, WAYS=2, WORDS=2).
// Memory is a fixed function of address with a configurable number of wait cycles before each word.
// A recency-queue model of the cache predicts hit/miss and counter values.
module tb_icache_assoc;

    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int WORDS = 2;
    localparam int CNT_W = 32;

    logic             CLK;
    logic             nRST;
    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             ihit;
    logic [31:0]      imemload;
    logic             iflush;
    logic             iREN;
    logic [31:0]      iaddr;
    logic             iwait;
    logic [31:0]      iload;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    int n_tests = 0;
    int n_fail  = 0;
    int wait_cfg  = 0;
    int wait_left = 0;

    logic [31:0] mdl_q[$];
    int          mdl_hits   = 0;
    int          mdl_misses = 0;

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        int          misses;
        int          hits;
    } vec_t;

    vec_t tbl[7];

    icache_assoc #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iflush     (iflush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign iload = mem_word(iaddr);
    assign iwait = (wait_left != 0);

    // Memory responder: wait_cfg busy cycles before each delivered word.
    always @(posedge CLK) begin
        if (iREN && wait_left != 0) wait_left <= wait_left - 1;
        else                        wait_left <= wait_cfg;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] blk(input logic [31:0] a);
        return a & ~32'(WORDS * 4 - 1);
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / (WORDS * 4)) % SETS);
    endfunction

    function automatic bit mdl_has(input logic [31:0] a);
        foreach (mdl_q[i]) if (mdl_q[i] == blk(a)) return 1'b1;
        return 1'b0;
    endfunction

    // Model: global recency queue of cached blocks, MRU at the front.
    task automatic mdl_access(input logic [31:0] a);
        int n_same;
        bit found;
        found = 1'b0;
        for (int i = 0; i < mdl_q.size(); i++) begin
            if (!found && mdl_q[i] == blk(a)) begin
                mdl_q.delete(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            mdl_misses++;
            n_same = 0;
            foreach (mdl_q[i]) if (set_of(mdl_q[i]) == set_of(a)) n_same++;
            if (n_same == WAYS) begin
                for (int i = mdl_q.size() - 1; i >= 0; i--) begin
                    if (set_of(mdl_q[i]) == set_of(a)) begin
                        mdl_q.delete(i);
                        break;
                    end
                end
            end
        end
        mdl_hits++;
        mdl_q.push_front(blk(a));
    endtask

    task automatic mdl_clear();
        mdl_q.delete();
    endtask

    // One fetch held until ihit; checks latency, refill addresses and returned data.
    task automatic do_access(input logic [31:0] a, input bit exp_hit, input int nw);
        int  got;
        bit  done;
        done = 1'b0;
        got  = 0;
        imemREN  = 1'b1;
        imemaddr = a;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge CLK);
            if (ihit) begin
                done = 1'b1;
                chk("hit_cycle", 64'(cyc), exp_hit ? 64'd0 : 64'(1 + WORDS * (nw + 1)));
                chk("hit_data", 64'(imemload), 64'(mem_word(a)));
                chk("hit_no_iREN", 64'(iREN), 64'd0);
            end else if (iREN) begin
                chk("fill_addr", 64'(iaddr), 64'(blk(a) + 32'(4 * got)));
                if (!iwait) got++;
            end
            @(posedge CLK);
            #1;
        end
        imemREN = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout: got no ihit, expected ihit for addr %0h", a);
        end else if (!exp_hit) begin
            chk("fill_words", 64'(got), 64'(WORDS));
        end
        mdl_access(a);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_hit_count"},  64'(hit_count),  64'(mdl_hits));
        chk({tag, "_miss_count"}, 64'(miss_count), 64'(mdl_misses));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          nw;

        tbl[0] = '{32'h100, 1'b0, 1, 1};
        tbl[1] = '{32'h104, 1'b1, 1, 2};
        tbl[2] = '{32'h200, 1'b0, 2, 3};
        tbl[3] = '{32'h100, 1'b1, 2, 4};
        tbl[4] = '{32'h300, 1'b0, 3, 5};
        tbl[5] = '{32'h100, 1'b1, 3, 6};
        tbl[6] = '{32'h200, 1'b0, 4, 7};

        nRST = 1'b0;
        imemREN = 1'b0;
        imemaddr = '0;
        iflush = 1'b0;
        #3;
        chk("rst_ihit", 64'(ihit), 64'd0);
        chk("rst_iREN", 64'(iREN), 64'd0);
        chk("rst_iaddr", 64'(iaddr), 64'd0);
        chk("rst_imemload", 64'(imemload), 64'd0);
        chk("rst_hit_count", 64'(hit_count), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Basic fill, spatial hit, conflict and LRU eviction.
        for (int i = 0; i < 7; i++) begin
            do_access(tbl[i].addr, tbl[i].hit, 0);
            chk("tbl_miss_count", 64'(miss_count), 64'(tbl[i].misses));
            chk("tbl_hit_count", 64'(hit_count), 64'(tbl[i].hits));
        end

        // Wait states: address stable across waits, hit one cycle after last word.
        wait_cfg = 3;
        do_access(32'h400, 1'b0, 3);
        wait_cfg = 0;
        do_access(32'h404, 1'b1, 0);
        chk_counts("wait");

        // Abort after the first refill word.
        imemREN = 1'b1;
        imemaddr = 32'h500;
        @(negedge CLK);
        chk("abort_c0_iREN", 64'(iREN), 64'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("abort_c1_iaddr", 64'(iaddr), 64'h500);
        @(posedge CLK); #1;
        imemREN = 1'b0;
        @(negedge CLK);
        chk("abort_iREN_drop", 64'(iREN), 64'd0);
        @(posedge CLK); #1;
        chk_counts("abort");
        do_access(32'h500, 1'b0, 0);
        chk_counts("abort_refetch");

        // Flush during a fill after four distinct blocks.
        do_access(32'h600, mdl_has(32'h600), 0);
        do_access(32'h608, mdl_has(32'h608), 0);
        do_access(32'h610, mdl_has(32'h610), 0);
        do_access(32'h618, mdl_has(32'h618), 0);
        imemREN = 1'b1;
        imemaddr = 32'h620;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("flush_pre_iREN", 64'(iREN), 64'd1);
        @(posedge CLK); #1;
        iflush = 1'b1;
        @(negedge CLK);
        chk("flush_iREN", 64'(iREN), 64'd0);
        @(posedge CLK); #1;
        iflush = 1'b0;
        imemREN = 1'b0;
        mdl_clear();
        chk_counts("flush");
        do_access(32'h600, 1'b0, 0);
        do_access(32'h608, 1'b0, 0);
        do_access(32'h610, 1'b0, 0);
        do_access(32'h618, 1'b0, 0);
        chk_counts("post_flush");

        // Flush wins over a would-be hit.
        imemREN = 1'b1;
        imemaddr = 32'h600;
        iflush = 1'b1;
        @(negedge CLK);
        chk("flush_hit_forced0", 64'(ihit), 64'd0);
        @(posedge CLK); #1;
        iflush = 1'b0;
        imemREN = 1'b0;
        mdl_clear();
        do_access(32'h600, 1'b0, 0);
        chk_counts("flush_hit");

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) begin
            a  = 32'($urandom_range(0, 95)) << 2;
            nw = int'($urandom_range(0, 1));
            wait_cfg = nw;
            do_access(a, mdl_has(a), nw);
        end
        wait_cfg = 0;
        chk_counts("random");

        // Asynchronous reset in the middle of a refill.
        do_access(32'h100, mdl_has(32'h100), 0);
        imemREN = 1'b1;
        imemaddr = 32'h700;
        @(posedge CLK); #1;
        #2;
        chk("arst_pre_iREN", 64'(iREN), 64'd1);
        nRST = 1'b0;
        #1;
        chk("arst_iREN", 64'(iREN), 64'd0);
        chk("arst_iaddr", 64'(iaddr), 64'd0);
        imemREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        mdl_clear();
        mdl_hits = 0;
        mdl_misses = 0;
        chk_counts("arst");
        do_access(32'h100, 1'b0, 0);
        chk_counts("arst_refill");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative, multi-word-block instruction cache, successor to the single-word direct-mapped icache.
- Sits between the datapath fetch stage (imem request/response) and the memory controller instruction channel (iREN/iaddr/iwait/iload).
- Adds associativity, LRU replacement, block refill of WORDS consecutive words, a flush input, and hit/miss counters.

Parameters:
- SETS, 8, number of sets; power of 2, >=2.
- WAYS, 2, associativity; power of 2, 1..4.
- WORDS, 2, 32-bit words per block; power of 2, 1..4.
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  fetch byte address; word aligned.
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  instruction word.
- iflush  in  1  invalidate all lines.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address.
- iwait  in  1  memory busy; word delivered when iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  CNT_W  number of cycles with ihit=1.
- miss_count  out  CNT_W  number of completed refills.

Behaviour:
- Address split: [1:0] byte (ignored); next log2(WORDS) bits = word offset; next log2(SETS) bits = index; remaining upper bits = tag.
- Each line holds valid, tag, WORDS data words. Each set holds LRU state: 1 bit for WAYS=2, a full age ordering for WAYS=4. WAYS=1 needs no LRU.
- Reset (async): all valid=0, all LRU=0, state=CHECK, fill counter=0, counters=0. Outputs ihit=0, imemload=0, iREN=0, iaddr=0.
- States: CHECK and FILL.
- CHECK, imemREN=1, tag match on a valid way: combinational ihit=1, imemload=matching word in the same cycle. At the clock edge, set LRU to mark that way most-recent and increment hit_count.
- CHECK, imemREN=1, no match:
  - ihit=0.
  - Latch block base address (word offset cleared).
  - Select victim: lowest-numbered invalid way; otherwise the LRU way.
  - Set fill counter=0; go to FILL.
- CHECK, imemREN=0: all outputs 0, no state change.
- FILL:
  - iREN=1, iaddr=latched base + 4*counter, ihit=0.
  - Each cycle with iwait=0: store iload into victim word[counter], increment counter.
  - On the last word (counter=WORDS-1, iwait=0): write victim tag, set valid=1, mark victim most-recent, increment miss_count, return to CHECK.
  - The next cycle hits; miss-to-hit latency with zero-wait memory is WORDS+1 cycles.
- imemaddr changing during FILL does not redirect the fill; the latched block completes.
- imemREN=0 during FILL: abort. Drop iREN that cycle; the victim line stays untouched (valid unchanged, partial words are not exposed); return to CHECK.
- iflush=1, any state: next edge clears all valid and LRU bits and aborts any fill (iREN=0 in the flush cycle, state=CHECK). ihit is forced 0 in the flush cycle. iflush has priority over fill completion.
- Counters wrap modulo 2^CNT_W. Aborted or flushed fills do not count.
- Output width rule: imemload and iaddr are always 32 bits regardless of parameters.

Test Plan:
- SETS=8, WAYS=2, WORDS=2, zero-wait memory.
  - Read 0x100: miss. Expect iaddr=0x100 then 0x104, ihit on cycle 3 with the mem[0x100] word.
  - Then read 0x104: ihit=1 same cycle, no iREN.
  - Expect miss_count=1, hit_count=2.
- Conflict and LRU:
  - Fill 0x100 (idx0, tag4), then 0x200 (idx0, tag8); re-read 0x100 (hit).
  - Read 0x300 (tag12): 0x200's way is evicted.
  - 0x100 still hits; 0x200 misses.
- Wait states: iwait=1 for 3 cycles before each word.
  - iREN stays 1 and iaddr stable during waits.
  - Line valid only after the second word is accepted; ihit appears on the following cycle.
- Abort: drop imemREN after the first fill word of 0x100.
  - iREN drops and the state returns to CHECK.
  - Reissuing 0x100 misses again and refetches both words.
  - miss_count increments once total.
- Flush: after filling 4 distinct blocks, pulse iflush during a fill of a fifth block.
  - iREN=0 that cycle.
  - All prior addresses miss afterwards; counters are unchanged by the flush.
- Async reset mid-FILL: assert nRST=0 between clock edges.
  - iREN=0 immediately.
  - Previously cached 0x100 misses after reset release; counters read 0.
